pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator for the actuator/motor drive path, fed from the HPS register bridge. One shared period counter drives `NUM_CH` independent duty comparators. Period and duty values are double-buffered: writes land in shadow registers and commit only at a period boundary, so no output ever sees a truncated or glitched pulse. Outputs are registered and go straight to FPGA pins.

## Interface
- `WIDTH`, 11: counter, period and duty width in bits.
- `NUM_CH`, 4: number of PWM channels (1..15).
- `AW`, 4: write address width; must satisfy 2^AW > NUM_CH.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = counter runs; 0 = counter held, outputs low.
- `wr_en` in 1: single-cycle write strobe; no backpressure.
- `wr_addr` in AW: 0 = period; 1..NUM_CH = duty of channel addr-1; any other value is ignored.
- `wr_data` in WIDTH: value written.
- `ch_en` in NUM_CH: per-channel enable; sampled every cycle, not buffered.
- `pwm_out` out NUM_CH: PWM outputs, registered.
- `cyc_start` out 1: one-cycle pulse, high in the cycle in which `cnt` = 0 is reflected on `pwm_out`.
- `upd_pending` out 1: high while any shadow write is not yet committed.

## Operation
- Registers:
  - Shadow period `per_s` and active period `per_a`.
  - Per-channel shadow duty `duty_s[i]` and active duty `duty_a[i]`.
  - Counter `cnt` and `pending` flag.
- Reset values:
  - `cnt` = 0; `per_s` = `per_a` = all ones; all `duty_s` and `duty_a` = 0.
  - `pwm_out` = 0, `cyc_start` = 0, `upd_pending` = 0.
- Edge-aligned counting (default): `cnt` counts 0..`per_a` inclusive, then wraps to 0. The period is `per_a`+1 cycles.
- Boundary: the cycle in which `cnt` == `per_a` (and `run`=1).
- Commit at the boundary edge:
  - `per_a` <= `per_s`; `duty_a` <= `duty_s` (all channels together); `pending` <= 0.
- Write in the boundary cycle:
  - Updates the shadow register and sets `pending`.
  - The commit on that edge uses the pre-write shadow value, so the new value commits at the next boundary.
- Write outside the boundary cycle: updates the shadow register and sets `pending`.
- Comparator: `pwm_out[i]` <= `run` & `ch_en[i]` & (`cnt` < `duty_a[i]`). Unsigned compare.
  - `duty` = 0 gives constant low.
  - `duty` > `per_a` gives constant high.
- `run`=0:
  - `cnt` <= 0; all outputs forced low next cycle.
  - Active registers track shadows every cycle (`active` <= `shadow`); `pending` <= 0.
  - On `run` rising, the first period starts at `cnt`=0 with the latest values.
- Shrinking the period below the current `cnt` cannot cause a runaway, because the period only changes at wrap.
- `rst` asserted mid-period: all state returns to reset values immediately, asynchronously.

## Timing
- Latency: `cnt` value to `pwm_out` is 1 cycle. `cyc_start` is registered alongside `pwm_out`, same alignment.
- Write to effect: the new value is visible on `pwm_out` 1 cycle after the first `cnt`=0 following the commit.
- `upd_pending`: goes high the cycle after `wr_en`; falls the cycle after the commit edge.
- Back-to-back writes to the same address: the last one before the boundary wins.
- Release of `rst`: the first counting edge is the first `clk` edge after release, with `run`=1.

## Configuration
- Macro `PWM_CENTER_ALIGN_EN`.
- Defined: up/down counting.
  - `cnt` goes 0→`per_a`→0. The period is 2·`per_a` cycles; `cnt`=0 and `per_a` each occur once per period.
  - Boundary is `cnt`=0 while counting down (the trough).
  - Comparator is unchanged, giving a pulse centred on the trough.
  - `cyc_start` marks the trough.
  - `per_a` = 0 holds `cnt` at 0.
- Undefined: edge-aligned counting only; the direction register is not synthesised.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_ADDR_PERIOD` = 0.
  - `PWM_ADDR_CH0` = 1.
  - Reset constant for the period (all ones).
- Sub-module `pwm_channel`:
  - One instance per channel via generate.
  - Holds `duty_s`/`duty_a`, the commit logic, the comparator and the output register.
- The top level holds the counter, period registers, `pending` and address decode.

## Test plan
- Reset, then `run`=1, all `ch_en`=1, period=9, ch0 duty=3 → ch0 high 3 of every 10 cycles; `cyc_start` every 10 cycles.
- ch1 duty=0 and ch2 duty=15 with period=9 → ch1 constantly low, ch2 constantly high.
- Write ch0 duty=7 at `cnt`=4 → current period stays 3-high; next period 7-high. `upd_pending` high from the write until the commit.
- Write period=4 exactly in the cycle `cnt`==9 → the following period is still 10 cycles; 5-cycle periods start after that.
- `run` dropped mid-pulse → `pwm_out` low the next cycle; a write while stopped applies immediately on `run` re-rise.
- With `PWM_CENTER_ALIGN_EN`, period=5, duty=2 → 10-cycle period; output high for `cnt`∈{1,0,1}, i.e. 3 consecutive cycles centred on the trough.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

    localparam int PWM_ADDR_PERIOD = 0;
    localparam int PWM_ADDR_CH0    = 1;

    // Period reset value is all ones; supports WIDTH up to PWM_MAX_WIDTH.
    localparam int                     PWM_MAX_WIDTH = 16;
    localparam logic [PWM_MAX_WIDTH-1:0] PWM_PER_RST = '1;

    // Counter direction, only meaningful for centre-aligned builds.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, comparator and registered output.
// Latency: cnt to pwm 1 cycle; duty write visible after the next commit.
// Backpressure: none; writes are single-cycle strobes always accepted.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_s_q, duty_s_d;
    logic [WIDTH-1:0] duty_a_q, duty_a_d;
    logic             pwm_q, pwm_d;

    // Shadow takes writes; active takes the pre-write shadow on commit.
    always_comb begin
        duty_s_d = duty_s_q;
        duty_a_d = duty_a_q;
        pwm_d    = 1'b0;
        if (wr_hit) begin
            duty_s_d = wr_data;
        end
        if (commit) begin
            duty_a_d = duty_s_q;
        end
        pwm_d = run & en & (cnt < duty_a_q);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_s_q <= '0;
            duty_a_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            duty_s_q <= duty_s_d;
            duty_a_q <= duty_a_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered period/duty, NUM_CH comparators.
// Latency: cnt to pwm_out/cyc_start 1 cycle; writes take effect at the next period boundary.
// Backpressure: none. Optional macro PWM_CENTER_ALIGN_EN selects up/down counting.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 11,
    parameter int NUM_CH = 4,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              cyc_start,
    output logic              upd_pending
);

    localparam logic [WIDTH-1:0] PER_RST = PWM_PER_RST[WIDTH-1:0];

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  per_s_q, per_s_d;
    logic [WIDTH-1:0]  per_a_q, per_a_d;
    logic              pending_q, pending_d;
    logic              cyc_q, cyc_d;
    logic              commit;
    logic              wr_per;
    logic              wr_any;
    logic [NUM_CH-1:0] duty_wr;

    assign wr_per = wr_en && (wr_addr == AW'(PWM_ADDR_PERIOD));
    assign wr_any = wr_en && (wr_addr <= AW'(NUM_CH));

`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_e dir_q, dir_d;

    // Up/down counter; commit happens at the trough (cnt 0 while counting down).
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        commit = 1'b0;
        if (!run) begin
            cnt_d  = '0;
            dir_d  = DIR_UP;
            commit = 1'b1;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= per_a_q) begin
                dir_d = DIR_DOWN;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == '0) begin
                commit = 1'b1;
                dir_d  = DIR_UP;
                // Next period starts climbing unless the committed period is zero.
                cnt_d  = (per_s_q == '0) ? '0 : WIDTH'(1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Direction register exists only in centre-aligned builds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Edge-aligned counter: 0..per_a inclusive, commit on the wrap edge.
    always_comb begin
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (!run) begin
            cnt_d  = '0;
            commit = 1'b1;
        end else if (cnt_q == per_a_q) begin
            cnt_d  = '0;
            commit = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`endif

    // Period shadow/active, pending flag (a write outranks the commit clear) and cycle marker.
    always_comb begin
        per_s_d   = per_s_q;
        per_a_d   = per_a_q;
        pending_d = pending_q;
        cyc_d     = 1'b0;
        if (wr_per) begin
            per_s_d = wr_data;
        end
        if (commit) begin
            per_a_d   = per_s_q;
            pending_d = 1'b0;
        end
        if (wr_any) begin
            pending_d = 1'b1;
        end
        cyc_d = run && (cnt_q == '0);
    end

    // Top-level state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            per_s_q   <= PER_RST;
            per_a_q   <= PER_RST;
            pending_q <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_s_q   <= per_s_d;
            per_a_q   <= per_a_d;
            pending_q <= pending_d;
            cyc_q     <= cyc_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_wr[i] = wr_en && (wr_addr == AW'(PWM_ADDR_CH0 + i));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .en      (ch_en[i]),
            .wr_hit  (duty_wr[i]),
            .wr_data (wr_data),
            .commit  (commit),
            .cnt     (cnt_q),
            .pwm     (pwm_out[i])
        );
    end

    assign cyc_start   = cyc_q;
    assign upd_pending = pending_q;

endmodule
